// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parameterised register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DATA_W_DEF = 20;
    localparam int ADDR_W_DEF = 4;

    // CLEAR walks every entry to zero after reset, READY serves normal traffic
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Post-reset clear sequencer: steps clr_addr over every entry, then releases busy.
// Latency: busy stays high for exactly 2**ADDR_W edges after rst is released.
// Backpressure: none; while busy the owner must ignore external writes.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;

    // State and clear counter registers; reset holds the sequence at entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next-state: count through every entry, leave CLEAR on the last one
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        busy          = 1'b0;
        clr_we        = 1'b0;
        case (r_state)
            CLEAR: begin
                busy          = 1'b1;
                clr_we        = 1'b1;
                // natural wrap brings the counter back to 0 on the final step
                w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                if (&r_clr_cnt) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign clr_addr = r_clr_cnt;

endmodule

// File: rtl/param_regfile.sv
// 1-write / 2-read register file with optional write-first bypass and hardwired zero entry.
// Latency: reads are registered, data appears one edge after rdN_en.
// Backpressure: writes issued while busy (clearing) are silently dropped.
module param_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd0_data;
    logic [DATA_W-1:0] r_rd1_data;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_ok;
    logic              w_fwd0;
    logic              w_fwd1;
    logic [DATA_W-1:0] w_rd0_val;
    logic [DATA_W-1:0] w_rd1_val;

    regfile_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // Read-side selection: zero entry, then bypass from the write port, then storage
    always_comb begin
        // a write to entry 0 of a zero-register file never lands, so it never forwards either
        w_wr_ok   = wr_en && !w_busy && !((ZERO_REG != 0) && (wr_addr == '0));
        w_fwd0    = (BYPASS != 0) && w_wr_ok && (rd0_addr == wr_addr);
        w_fwd1    = (BYPASS != 0) && w_wr_ok && (rd1_addr == wr_addr);
        w_rd0_val = r_mem[rd0_addr];
        w_rd1_val = r_mem[rd1_addr];
        if ((ZERO_REG != 0) && (rd0_addr == '0)) begin
            w_rd0_val = '0;
        end else if (w_fwd0) begin
            w_rd0_val = wr_data;
        end
        if ((ZERO_REG != 0) && (rd1_addr == '0)) begin
            w_rd1_val = '0;
        end else if (w_fwd1) begin
            w_rd1_val = wr_data;
        end
    end

    // Storage: no reset of its own, zeroed by the clear walk, then written by the user port
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_mem[w_clr_addr] <= '0;
            end else if (w_wr_ok) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    // Registered read ports: forced to zero while clearing, hold when not enabled
    always_ff @(posedge clk) begin
        if (rst || w_busy) begin
            r_rd0_data <= '0;
            r_rd1_data <= '0;
        end else begin
            if (rd0_en) begin
                r_rd0_data <= w_rd0_val;
            end
            if (rd1_en) begin
                r_rd1_data <= w_rd1_val;
            end
        end
    end

    assign rd0_data = r_rd0_data;
    assign rd1_data = r_rd1_data;
    assign busy     = w_busy;

endmodule

// File: tb/tb_param_regfile.sv
// Scoreboard bench for param_regfile in three configurations driven by shared stimulus.
// Latency: expected values are queued one edge ahead of the outputs they describe.
// Backpressure: n/a.
module tb_param_regfile;

    localparam int NCFG = 3;   // 0: defaults, 1: BYPASS=0, 2: ZERO_REG=1

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [19:0] wr_data;
    logic        rd0_en;
    logic [3:0]  rd0_addr;
    logic        rd1_en;
    logic [3:0]  rd1_addr;

    logic [19:0] rd0_data [NCFG];
    logic [19:0] rd1_data [NCFG];
    logic        busy     [NCFG];

    always #5 clk = ~clk;

    param_regfile u_dut_def (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data[0]),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data[0]), .busy(busy[0])
    );

    param_regfile #(.BYPASS(0)) u_dut_nobyp (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data[1]),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data[1]), .busy(busy[1])
    );

    param_regfile #(.ZERO_REG(1)) u_dut_zero (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data[2]),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data[2]), .busy(busy[2])
    );

    typedef struct packed {
        logic [NCFG-1:0][19:0] r0;
        logic [NCFG-1:0][19:0] r1;
        logic [NCFG-1:0]       b;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: contents per configuration, edges seen since reset release
    logic [19:0] m_mem   [NCFG][16];
    logic [19:0] m_last0 [NCFG];
    logic [19:0] m_last1 [NCFG];
    int          m_since = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int c, input logic [19:0] act, input logic [19:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cfg%0d: got %h expected %h at %0t", name, c, act, expv, $time);
        end
    endtask

    // Monitor: after every edge, compare outputs with the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int c = 0; c < NCFG; c++) begin
                    chk("rd0_data", c, rd0_data[c], e.r0[c]);
                    chk("rd1_data", c, rd1_data[c], e.r1[c]);
                    chk("busy", c, {19'd0, busy[c]}, {19'd0, e.b[c]});
                end
            end
        end
    end

    // One clock of stimulus; the model predicts the outputs after the coming edge
    task automatic step(input logic r, input logic we, input logic [3:0] wa, input logic [19:0] wd,
                        input logic e0, input logic [3:0] a0, input logic e1, input logic [3:0] a1);
        exp_t e;
        bit   byp;
        bit   zr;
        bit   wok;
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd0_en = e0; rd0_addr = a0; rd1_en = e1; rd1_addr = a1;
        e = '0;
        if (r) begin
            // contents read back as zero from here on until rewritten
            m_since = 0;
            for (int c = 0; c < NCFG; c++) begin
                m_last0[c] = '0;
                m_last1[c] = '0;
                for (int k = 0; k < 16; k++) m_mem[c][k] = '0;
            end
            e.b = '1;
        end else if (m_since < 16) begin
            m_since++;
            for (int c = 0; c < NCFG; c++) begin
                m_last0[c] = '0;
                m_last1[c] = '0;
            end
            e.b = (m_since < 16) ? '1 : '0;
        end else begin
            for (int c = 0; c < NCFG; c++) begin
                byp = (c != 1);
                zr  = (c == 2);
                wok = we && !(zr && wa == 4'd0);
                if (e0) m_last0[c] = (zr && a0 == 4'd0) ? 20'd0 : (byp && wok && a0 == wa) ? wd : m_mem[c][a0];
                if (e1) m_last1[c] = (zr && a1 == 4'd0) ? 20'd0 : (byp && wok && a1 == wa) ? wd : m_mem[c][a1];
                if (wok) m_mem[c][wa] = wd;
            end
            e.b = '0;
        end
        for (int c = 0; c < NCFG; c++) begin
            e.r0[c] = m_last0[c];
            e.r1[c] = m_last1[c];
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 20'd0, 1'b1, 4'($urandom), 1'b1, 4'($urandom));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd0_en = 1'b0; rd0_addr = '0; rd1_en = 1'b0; rd1_addr = '0;

        // reset for two cycles, then the full clear walk
        step(1'b1, 1'b0, 4'd0, 20'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0, 20'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        idle(17);
        // every entry reads zero after the clear
        for (int a = 0; a < 16; a++) step(1'b0, 1'b0, 4'd0, 20'd0, 1'b1, 4'(a), 1'b1, 4'(15 - a));

        // write then read from both ports
        step(1'b0, 1'b1, 4'd5, 20'hABCDE, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 20'd0, 1'b1, 4'd5, 1'b1, 4'd5);
        // same-edge write and read of address 3
        step(1'b0, 1'b1, 4'd3, 20'h11111, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd3, 20'h22222, 1'b1, 4'd3, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 20'd0, 1'b1, 4'd3, 1'b1, 4'd3);
        // hold behaviour with reads disabled
        step(1'b0, 1'b1, 4'd3, 20'h33333, 1'b0, 4'd3, 1'b0, 4'd3);
        // zero entry: write with same-edge read, then later read
        step(1'b0, 1'b1, 4'd0, 20'hFFFFF, 1'b1, 4'd0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 4'd0, 20'd0, 1'b1, 4'd0, 1'b1, 4'd0);

        // write attempted on clear edge 3 is dropped
        step(1'b1, 1'b0, 4'd0, 20'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        idle(2);
        step(1'b0, 1'b1, 4'd7, 20'h12345, 1'b1, 4'd7, 1'b1, 4'd7);
        idle(14);
        step(1'b0, 1'b0, 4'd0, 20'd0, 1'b1, 4'd7, 1'b1, 4'd7);

        // reset re-asserted at clear edge 10 restarts the full walk
        step(1'b0, 1'b1, 4'd9, 20'h0F0F0, 1'b0, 4'd0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0, 20'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        idle(9);
        step(1'b1, 1'b1, 4'd9, 20'h55555, 1'b1, 4'd9, 1'b1, 4'd9);
        idle(17);
        step(1'b0, 1'b0, 4'd0, 20'd0, 1'b1, 4'd9, 1'b1, 4'd9);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 1) == 1), 4'($urandom), 20'($urandom),
                 ($urandom_range(0, 3) != 0), 4'($urandom),
                 ($urandom_range(0, 3) != 0), 4'($urandom));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_regfile.md
PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 20, giving the data width of each entry.
REQ-002 The block SHALL have parameter ADDR_W, default 4, giving the address width; DEPTH = 2**ADDR_W is derived and is not overridable.
REQ-003 The block SHALL have parameter BYPASS, default 1: 1 = write-first same-cycle forwarding, 0 = read-before-write.
REQ-004 The block SHALL have parameter ZERO_REG, default 0: 1 = entry 0 is hardwired to zero.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset; the ports are listed in REQ-006 to REQ-017.
REQ-006 clk  in  1  sole clock; all state is updated on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wr_en  in  1  write strobe.
REQ-009 wr_addr  in  ADDR_W  write address.
REQ-010 wr_data  in  DATA_W  write data.
REQ-011 rd0_en  in  1  read-port-0 enable.
REQ-012 rd0_addr  in  ADDR_W  read-port-0 address.
REQ-013 rd0_data  out  DATA_W  registered read-port-0 data.
REQ-014 rd1_en  in  1  read-port-1 enable.
REQ-015 rd1_addr  in  ADDR_W  read-port-1 address.
REQ-016 rd1_data  out  DATA_W  registered read-port-1 data.
REQ-017 busy  out  1  high while the clear sequence runs.

Function
REQ-018 The block SHALL hold DEPTH entries of DATA_W bits each, with one write port and two independent read ports.
REQ-019 The block SHALL implement a two-state FSM: CLEAR (busy=1) and READY (busy=0).
REQ-020 In CLEAR, on each edge with rst=0, the block SHALL write zero to mem[clr_cnt] and increment clr_cnt, which is ADDR_W bits wide.
REQ-021 When clr_cnt == DEPTH-1, the block SHALL go to READY on that edge, so busy falls exactly DEPTH edges after rst is released.
REQ-022 In READY, on an edge with wr_en=1, the block SHALL write mem[wr_addr] <= wr_data.
REQ-023 In CLEAR, the block SHALL drop wr_en: there is no queueing and no error flag.
REQ-024 In READY, on an edge with rdN_en=1, rdN_data SHALL take the entry at rdN_addr (1-cycle latency); with rdN_en=0, rdN_data SHALL hold its value.
REQ-025 In CLEAR, both rdN_data outputs SHALL be forced to 0 regardless of rdN_en.
REQ-026 BYPASS=1: if wr_en=1, rdN_en=1 and rdN_addr == wr_addr on the same edge, rdN_data SHALL take wr_data.
REQ-027 BYPASS=0: under the same conditions as REQ-026, rdN_data SHALL take the old entry value.
REQ-028 ZERO_REG=1: writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and bypass SHALL NOT forward address 0.
REQ-029 Both read ports SHALL be able to read the same address simultaneously, with identical results.
REQ-030 The write address SHALL use full DEPTH decoding with no wrap or aliasing; clr_cnt SHALL wrap to 0 only on the CLEAR to READY transition.

Reset
REQ-031 On any edge with rst=1, the block SHALL set state=CLEAR, clr_cnt=0, busy=1, rd0_data=0 and rd1_data=0.
REQ-032 While rst is held high, the block SHALL NOT advance clearing; clearing begins on the first edge with rst=0.
REQ-033 If rst is asserted mid-CLEAR or in READY, the block SHALL restart the sequence from entry 0.
REQ-034 rst SHALL take priority over wr_en and rdN_en.
REQ-035 The memory array SHALL have no reset of its own; it is initialised only by the clear sequence.

Structure
REQ-036 Shared package regfile_pkg SHALL hold the FSM state type (CLEAR, READY) and the default DATA_W/ADDR_W constants.
REQ-037 The FSM and clr_cnt SHALL live in sub-module regfile_clear_ctrl, which outputs busy, clr_we and clr_addr.
REQ-038 The storage, read ports and bypass logic SHALL stay in param_regfile.
REQ-039 The total implementation SHALL be 120-400 RTL lines.

Verification
REQ-040 Reset clear: defaults, pulse rst for 2 cycles, release -> busy=1 for exactly 16 edges, then 0; reading every address 0..15 returns 0x00000.
REQ-041 Write/read: write 0xABCDE to addr 5, next cycle rd0_addr=5 and rd1_addr=5 -> both outputs 0xABCDE one edge later.
REQ-042 Bypass: mem[3]=0x11111, same edge wr 0x22222 to addr 3 with rd0_addr=3 -> rd0_data=0x22222 with BYPASS=1, 0x11111 with BYPASS=0.
REQ-043 Write during busy: wr_en=1, addr 7, 0x12345 on clear edge 3 -> after READY, reading addr 7 returns 0x00000.
REQ-044 Mid-clear reset: assert rst at clear edge 10 -> busy stays high for 16 further edges after release; rd_data=0 throughout.
REQ-045 ZERO_REG=1: write 0xFFFFF to addr 0 with rd0_addr=0 on the same edge -> rd0_data=0x00000; later read of addr 0 returns 0x00000.
